// File: rtl/voter_pkg.sv
// Shared voter types: voter count, collector states, ballot type.
// Imported by the collector and by the downstream majority decoder.
package voter_pkg;

  localparam int N_VOTERS = 4;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    DONE
  } state_t;

  typedef logic [N_VOTERS-1:0] ballot_t;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer plus history flop for one raw button input.
// Ports: clk, rst_n, d_async (raw button), rise (one-cycle edge pulse).
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);

  logic s1;
  logic s2;
  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1   <= d_async;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign rise = s2 & ~hist;

endmodule

// File: rtl/vote_collector.sv
// Timed voting session: one yes-press per voter, latched ballot out.
// Ports: clk, rst_n, start, abort, press[3:0] in; ballot, ballot_valid, busy, voted out.
module vote_collector
  import voter_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W = $clog2(WINDOW_CYCLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N_VOTERS-1:0] press,
  output logic [N_VOTERS-1:0] ballot,
  output logic                ballot_valid,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WINDOW_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_n;
  ballot_t          voted_q;
  ballot_t          voted_n;
  ballot_t          ballot_q;
  ballot_t          ballot_n;
  ballot_t          rise;
  ballot_t          merged;

  for (genvar i = 0; i < N_VOTERS; i++) begin : g_in
    sync_rise u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_async(press[i]),
      .rise   (rise[i])
    );
  end

  // Rises in the closing cycle still count.
  assign merged = voted_q | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      voted_q  <= '0;
      ballot_q <= '0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      voted_q  <= voted_n;
      ballot_q <= ballot_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    voted_n  = voted_q;
    ballot_n = ballot_q;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = OPEN;
          timer_n = '0;
          voted_n = '0;
        end
      end
      OPEN: begin
        if (abort) begin
          state_n = IDLE;
          voted_n = '0;
        end else begin
          voted_n = merged;
          // Timer holds at close so it never wraps.
          if (timer == LAST || merged == '1) begin
            state_n  = DONE;
            ballot_n = merged;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign ballot       = ballot_q;
  assign voted        = voted_q;
  assign ballot_valid = (state == DONE);
  assign busy         = (state == OPEN);

endmodule
